// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button front end: channel FSM states and
// default timing constants for a 100 MHz clock.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 32'd50000000;
  localparam int unsigned DEF_REPEAT_RATE     = 32'd10000000;
  localparam int unsigned DEF_CTR_W           = 32'd27;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability-counter FSM and
// auto-repeat timer producing a clean level plus press/release/repeat strobes.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = 32'd1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned CTR_W           = DEF_CTR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam logic [CTR_W-1:0] ZERO     = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] ONE      = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [CTR_W-1:0] DB_LIM   = CTR_W'(DEBOUNCE_CYCLES);
  localparam logic [CTR_W-1:0] RPT_DLY  = CTR_W'(REPEAT_DELAY);
  localparam logic [CTR_W-1:0] RPT_RATE = CTR_W'(REPEAT_RATE);

  logic [1:0]       sync_r;
  logic             sync_s;
  btn_state_e       state_r;
  logic [CTR_W-1:0] cnt_r;
  logic [CTR_W-1:0] rcnt_r;
  logic             rphase_r;
  logic [CTR_W-1:0] rcnt_next_s;
  logic [CTR_W-1:0] rtarget_s;

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v,
                                               input logic [CTR_W-1:0] lim);
    if (v >= lim) begin
      sat_inc = lim;
    end else begin
      sat_inc = v + ONE;
    end
  endfunction

  // Two-flop synchroniser for the asynchronous pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
    end
  end

  assign sync_s = sync_r[1];

  // Repeat target: first strobe after REPEAT_DELAY, later ones every REPEAT_RATE.
  always_comb begin
    rcnt_next_s = rcnt_r + ONE;
    if (rphase_r) begin
      rtarget_s = RPT_RATE;
    end else begin
      rtarget_s = RPT_DLY;
    end
  end

  // Channel FSM with registered level and strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= ZERO;
      rcnt_r      <= ZERO;
      rphase_r    <= 1'b0;
      btn_db      <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sync_s) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= ONE;
          end else begin
            cnt_r   <= ZERO;
          end
        end
        PRESS_WAIT: begin
          if (!sync_s) begin
            state_r <= IDLE;
            cnt_r   <= ZERO;
          end else if (cnt_r >= DB_LIM) begin
            state_r   <= HELD;
            btn_db    <= 1'b1;
            btn_press <= 1'b1;
            cnt_r     <= ZERO;
            rcnt_r    <= ZERO;
            rphase_r  <= 1'b0;
          end else begin
            cnt_r <= sat_inc(cnt_r, DB_LIM);
          end
        end
        HELD: begin
          if (!sync_s) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= ONE;
          end else if (REPEAT_EN != 32'd0) begin
            // Reload to zero on each strobe so the cadence never drifts.
            if (rcnt_next_s >= rtarget_s) begin
              btn_repeat <= 1'b1;
              rcnt_r     <= ZERO;
              rphase_r   <= 1'b1;
            end else begin
              rcnt_r <= rcnt_next_s;
            end
          end else begin
            rcnt_r <= ZERO;
          end
        end
        RELEASE_WAIT: begin
          if (sync_s) begin
            state_r <= HELD;
            cnt_r   <= ZERO;
          end else if (cnt_r >= DB_LIM) begin
            state_r     <= IDLE;
            btn_db      <= 1'b0;
            btn_release <= 1'b1;
            cnt_r       <= ZERO;
          end else begin
            cnt_r <= sat_inc(cnt_r, DB_LIM);
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= ZERO;
          rcnt_r   <= ZERO;
          rphase_r <= 1'b0;
          btn_db   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Board push-button front end: N_BTN independent debounce channels plus an
// OR of all press strobes.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned N_BTN           = 32'd5,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = 32'd1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned CTR_W           = DEF_CTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CTR_W          (CTR_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_db     (btn_db[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

  // Press strobes are registered, so this OR has no path from the pins.
  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised bench for button_debouncer with a run-length reference model
// and directed latency checks.
module tb_button_debouncer;
  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw, btn_db, btn_press, btn_release, btn_repeat;
  logic         any_press;

  always #5 clk = ~clk;

  button_debouncer #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .CTR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_db(btn_db),
    .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: raw samples reach the decision logic two edges late; a
  // level change is accepted after D+1 consecutive differing samples; held
  // counts only steady-pressed samples.
  logic [N-1:0] p1, p2, m_db, m_press, m_rel, m_rep;
  int run [N];
  int held[N];

  task automatic model_step();
    logic [N-1:0] samp;
    m_press = '0; m_rel = '0; m_rep = '0;
    if (rst) begin
      p1 = '0; p2 = '0; m_db = '0;
      for (int i = 0; i < N; i++) begin run[i] = 0; held[i] = 0; end
    end else begin
      samp = p2; p2 = p1; p1 = btn_raw;
      for (int i = 0; i < N; i++) begin
        if (samp[i] != m_db[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            m_db[i] = ~m_db[i];
            if (m_db[i]) begin m_press[i] = 1'b1; held[i] = 0; end
            else m_rel[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          if (m_db[i] && run[i] == 0) begin
            held[i]++;
            if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RR == 0))
              m_rep[i] = 1'b1;
          end
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("btn_db", btn_db, m_db);
      chk("btn_press", btn_press, m_press);
      chk("btn_release", btn_release, m_rel);
      chk("btn_repeat", btn_repeat, m_rep);
      chk("any_press", {{(N-1){1'b0}}, any_press}, {{(N-1){1'b0}}, |m_press});
    end
  end

  task automatic cyc(input logic [N-1:0] raw, input logic r);
    btn_raw = raw; rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Steps with raw held until the selected strobe appears; returns edges used or -1.
  task automatic wait_bit(input int ch, input int kind, input logic [N-1:0] raw, output int n);
    logic hit;
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc(raw, 1'b0);
      case (kind)
        0:       hit = btn_press[ch];
        1:       hit = btn_release[ch];
        default: hit = btn_repeat[ch];
      endcase
      if (hit) begin n = k; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [N-1:0] r;
    btn_raw = '0; rst = 1'b1;
    cyc('0, 1'b1);
    chk_en = 1'b1;
    cyc('0, 1'b1);
    lit("reset_db", int'(btn_db), 0);
    for (int i = 0; i < 4; i++) cyc('0, 1'b0);

    // Clean press and release on channel 0.
    wait_bit(0, 0, 5'b00001, n);
    lit("press_latency", n - 1, 6);
    lit("press_any", int'(any_press), 1);
    lit("press_db", int'(btn_db[0]), 1);
    cyc(5'b00001, 1'b0);
    lit("press_one_cycle", int'(btn_press[0]), 0);
    wait_bit(0, 1, 5'b00000, n);
    lit("release_latency", n - 1, 6);
    for (int i = 0; i < 4; i++) cyc('0, 1'b0);

    // Bounce: 1,0,1,1,0 then held 1.
    cyc(5'b00001, 1'b0); cyc(5'b00000, 1'b0); cyc(5'b00001, 1'b0);
    cyc(5'b00001, 1'b0); cyc(5'b00000, 1'b0);
    wait_bit(0, 0, 5'b00001, n);
    lit("bounce_latency", n - 1, 6);
    for (int i = 0; i < 10; i++) cyc('0, 1'b0);

    // Auto-repeat on channel 1.
    wait_bit(1, 0, 5'b00010, n);
    lit("rpt_press", n - 1, 6);
    wait_bit(1, 2, 5'b00010, n);
    lit("rpt_first", n, 10);
    wait_bit(1, 2, 5'b00010, n);
    lit("rpt_rate", n, 3);
    wait_bit(1, 1, 5'b00000, n);
    lit("rpt_release", n - 1, 6);
    for (int i = 0; i < 4; i++) cyc('0, 1'b0);

    // Release glitch: cadence resumes from the frozen count.
    wait_bit(1, 0, 5'b00010, n);
    wait_bit(1, 2, 5'b00010, n);
    lit("glitch_first_rpt", n, 10);
    cyc(5'b00000, 1'b0); cyc(5'b00000, 1'b0);
    wait_bit(1, 2, 5'b00010, n);
    lit("glitch_resume", n, 4);
    lit("glitch_db", int'(btn_db[1]), 1);
    for (int i = 0; i < 12; i++) cyc('0, 1'b0);

    // Reset in PRESS_WAIT, then in HELD, with the button still down.
    for (int i = 0; i < 4; i++) cyc(5'b00001, 1'b0);
    cyc(5'b00001, 1'b1);
    lit("rst_pw_db", int'(btn_db), 0);
    wait_bit(0, 0, 5'b00001, n);
    lit("rst_pw_repress", n - 1, 6);
    for (int i = 0; i < 3; i++) cyc(5'b00001, 1'b0);
    cyc(5'b00001, 1'b1);
    lit("rst_held_db", int'(btn_db), 0);
    wait_bit(0, 0, 5'b00001, n);
    lit("rst_held_repress", n - 1, 6);
    for (int i = 0; i < 10; i++) cyc('0, 1'b0);

    // Parallel channels 2 and 4.
    wait_bit(2, 0, 5'b10100, n);
    lit("par_latency", n - 1, 6);
    lit("par_press", int'(btn_press), 20);
    lit("par_db", int'(btn_db), 20);
    lit("par_any", int'(any_press), 1);
    cyc(5'b10100, 1'b0);
    lit("par_any_once", int'(any_press), 0);
    for (int i = 0; i < 10; i++) cyc('0, 1'b0);

    // Random bouncy traffic with occasional reset.
    r = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      cyc(r, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
